// File: rtl/corevx_lsu_pkg.sv
// Shared load/store unit definitions: command encodings, cache interface codes,
// exception causes and the LSU state enum. Used by execute and the LSU.
package corevx_lsu_pkg;

    localparam int unsigned LSU_CMD_W    = 2;
    localparam int unsigned FUNCT3_W     = 3;
    localparam int unsigned CACHE_CMD_W  = 4;
    localparam int unsigned CACHE_RESP_W = 4;
    localparam int unsigned CAUSE_W      = 32;

    // Execute-side operation encodings
    localparam logic [LSU_CMD_W-1:0] LSU_CMD_LOAD  = 2'd0;
    localparam logic [LSU_CMD_W-1:0] LSU_CMD_STORE = 2'd1;
    localparam logic [LSU_CMD_W-1:0] LSU_CMD_FLUSH = 2'd2;

    // Data-cache command/response codes
    localparam logic [CACHE_CMD_W-1:0] CACHE_CMD_NONE      = 4'd0;
    localparam logic [CACHE_CMD_W-1:0] CACHE_CMD_LOAD      = 4'd1;
    localparam logic [CACHE_CMD_W-1:0] CACHE_CMD_STORE     = 4'd2;
    localparam logic [CACHE_CMD_W-1:0] CACHE_CMD_FLUSH_ALL = 4'd3;

    localparam logic [CACHE_RESP_W-1:0] CACHE_RESPONSE_NONE        = 4'd0;
    localparam logic [CACHE_RESP_W-1:0] CACHE_RESPONSE_WAIT        = 4'd1;
    localparam logic [CACHE_RESP_W-1:0] CACHE_RESPONSE_DONE        = 4'd2;
    localparam logic [CACHE_RESP_W-1:0] CACHE_RESPONSE_MISSALIGNED = 4'd3;
    localparam logic [CACHE_RESP_W-1:0] CACHE_RESPONSE_ACCESSFAULT = 4'd4;
    localparam logic [CACHE_RESP_W-1:0] CACHE_RESPONSE_PAGEFAULT   = 4'd5;

    // RISC-V mcause exception codes
    localparam logic [CAUSE_W-1:0] EXCEPTION_CODE_LOAD_ADDRESS_MISALIGNED  = 32'd4;
    localparam logic [CAUSE_W-1:0] EXCEPTION_CODE_LOAD_ACCESS_FAULT        = 32'd5;
    localparam logic [CAUSE_W-1:0] EXCEPTION_CODE_STORE_ADDRESS_MISALIGNED = 32'd6;
    localparam logic [CAUSE_W-1:0] EXCEPTION_CODE_STORE_ACCESS_FAULT       = 32'd7;
    localparam logic [CAUSE_W-1:0] EXCEPTION_CODE_LOAD_PAGE_FAULT          = 32'd13;
    localparam logic [CAUSE_W-1:0] EXCEPTION_CODE_STORE_PAGE_FAULT         = 32'd15;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ISSUE,
        LSU_WAIT,
        LSU_RESP
    } lsu_state_e;

    // Control fields of the latched operation
    typedef struct packed {
        logic [LSU_CMD_W-1:0] cmd;
        logic [FUNCT3_W-1:0]  funct3;
    } lsu_ctrl_t;

    // Map an LSU command onto the cache command it issues
    function automatic logic [CACHE_CMD_W-1:0] lsu_cache_cmd(input logic [LSU_CMD_W-1:0] cmd);
        logic [CACHE_CMD_W-1:0] c;
        case (cmd)
            LSU_CMD_LOAD:  c = CACHE_CMD_LOAD;
            LSU_CMD_STORE: c = CACHE_CMD_STORE;
            default:       c = CACHE_CMD_FLUSH_ALL;
        endcase
        return c;
    endfunction

    // Exception cause for a completed operation; flush reports as a store
    function automatic logic [CAUSE_W-1:0] lsu_cause(input logic is_load,
                                                     input logic [CACHE_RESP_W-1:0] resp);
        logic [CAUSE_W-1:0] c;
        case (resp)
            CACHE_RESPONSE_DONE:
                c = '0;
            CACHE_RESPONSE_MISSALIGNED:
                c = is_load ? EXCEPTION_CODE_LOAD_ADDRESS_MISALIGNED
                            : EXCEPTION_CODE_STORE_ADDRESS_MISALIGNED;
            CACHE_RESPONSE_PAGEFAULT:
                c = is_load ? EXCEPTION_CODE_LOAD_PAGE_FAULT
                            : EXCEPTION_CODE_STORE_PAGE_FAULT;
            default:
                c = is_load ? EXCEPTION_CODE_LOAD_ACCESS_FAULT
                            : EXCEPTION_CODE_STORE_ACCESS_FAULT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/corevx_lsu_align.sv
// Combinational access-size alignment checker (shared with fetch).
module corevx_lsu_align
    import corevx_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0] size_i,
    input  logic [2:0] addr_lo_i,
    input  logic       check_en_i,
    output logic       misaligned_c_o
);

    // Natural alignment per size; a doubleword on a 32-bit core is never legal
    always_comb begin
        misaligned_c_o = 1'b0;
        if (check_en_i) begin
            case (size_i)
                2'd0:    misaligned_c_o = 1'b0;
                2'd1:    misaligned_c_o = addr_lo_i[0];
                2'd2:    misaligned_c_o = |addr_lo_i[1:0];
                default: misaligned_c_o = (XLEN == 64) ? (|addr_lo_i) : 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/corevx_lsu.sv
// Load/store unit: accepts one operation from execute, checks alignment, runs the
// data-cache command/response handshake and returns a tagged completion.
// Optional watchdog on the cache wait: define COREVX_LSU_TIMEOUT_EN.
module corevx_lsu
    import corevx_lsu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TAG_W          = 5,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [LSU_CMD_W-1:0]    req_cmd,
    input  logic [FUNCT3_W-1:0]     req_funct3,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [XLEN-1:0]         req_wdata,
    input  logic [TAG_W-1:0]        req_tag,
    input  logic                    kill,
    output logic                    resp_valid,
    output logic [XLEN-1:0]         resp_rdata,
    output logic [TAG_W-1:0]        resp_tag,
    output logic                    resp_exc,
    output logic [CAUSE_W-1:0]      resp_cause,
    input  logic                    c_reset_done,
    output logic [CACHE_CMD_W-1:0]  c_cmd,
    output logic [ADDR_W-1:0]       c_address,
    output logic [FUNCT3_W-1:0]     c_load_type,
    output logic [1:0]              c_store_type,
    output logic [XLEN-1:0]         c_store_data,
    input  logic [CACHE_RESP_W-1:0] c_response,
    input  logic [XLEN-1:0]         c_load_data
);

    lsu_state_e             state_q, state_d;
    lsu_ctrl_t              ctrl_q, ctrl_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [XLEN-1:0]        wdata_q, wdata_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic                   killed_q, killed_d;
    logic [CACHE_CMD_W-1:0] c_cmd_q, c_cmd_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_exc_q, resp_exc_d;
    logic [CAUSE_W-1:0]     resp_cause_q, resp_cause_d;
    logic [XLEN-1:0]        resp_rdata_q, resp_rdata_d;
    logic [TAG_W-1:0]       resp_tag_q, resp_tag_d;

    logic                   accept_c;
    logic                   misaligned_c;
    logic                   finish_c;
    logic                   fin_exc_c;
    logic [CAUSE_W-1:0]     fin_cause_c;
    logic [XLEN-1:0]        fin_rdata_c;
    logic                   op_is_load_c;
    logic                   cache_final_c;

`ifdef COREVX_LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]       cnt_q, cnt_d;
`endif

    assign req_ready     = (state_q == LSU_IDLE) && c_reset_done && !rst;
    assign accept_c      = req_valid && req_ready;
    assign op_is_load_c  = (ctrl_q.cmd == LSU_CMD_LOAD);
    assign cache_final_c = (c_response != CACHE_RESPONSE_NONE) &&
                           (c_response != CACHE_RESPONSE_WAIT);

    corevx_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .size_i         (req_funct3[1:0]),
        .addr_lo_i      (req_addr[2:0]),
        .check_en_i     (req_cmd != LSU_CMD_FLUSH),
        .misaligned_c_o (misaligned_c)
    );

    // Next-state, operation latches and completion result
    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        tag_d        = tag_q;
        killed_d     = killed_q;
        c_cmd_d      = CACHE_CMD_NONE;
        resp_valid_d = 1'b0;
        resp_exc_d   = resp_exc_q;
        resp_cause_d = resp_cause_q;
        resp_rdata_d = resp_rdata_q;
        resp_tag_d   = resp_tag_q;
        finish_c     = 1'b0;
        fin_exc_c    = 1'b0;
        fin_cause_c  = '0;
        fin_rdata_c  = '0;
`ifdef COREVX_LSU_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif

        case (state_q)
            LSU_IDLE: begin
                if (accept_c) begin
                    ctrl_d   = '{cmd: req_cmd, funct3: req_funct3};
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    tag_d    = req_tag;
                    killed_d = kill;
                    if (misaligned_c) begin
                        state_d     = LSU_RESP;
                        finish_c    = 1'b1;
                        fin_exc_c   = 1'b1;
                        fin_cause_c = lsu_cause(req_cmd == LSU_CMD_LOAD,
                                                CACHE_RESPONSE_MISSALIGNED);
                    end else begin
                        state_d = LSU_ISSUE;
                        c_cmd_d = lsu_cache_cmd(req_cmd);
                    end
                end
            end
            LSU_ISSUE: begin
                killed_d = killed_q | kill;
                state_d  = LSU_WAIT;
`ifdef COREVX_LSU_TIMEOUT_EN
                cnt_d    = '0;
`endif
            end
            LSU_WAIT: begin
                killed_d = killed_q | kill;
                if (cache_final_c) begin
                    state_d     = LSU_RESP;
                    finish_c    = 1'b1;
                    fin_exc_c   = (c_response != CACHE_RESPONSE_DONE);
                    fin_cause_c = lsu_cause(op_is_load_c, c_response);
                    fin_rdata_c = (op_is_load_c && c_response == CACHE_RESPONSE_DONE)
                                  ? c_load_data : '0;
                end
`ifdef COREVX_LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d     = LSU_RESP;
                    finish_c    = 1'b1;
                    fin_exc_c   = 1'b1;
                    fin_cause_c = lsu_cause(op_is_load_c, CACHE_RESPONSE_ACCESSFAULT);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            LSU_RESP: begin
                state_d  = LSU_IDLE;
                killed_d = 1'b0;
            end
            default: begin
                state_d  = LSU_IDLE;
                killed_d = 1'b0;
            end
        endcase

        // Publish the result in the RESP cycle unless the operation was killed
        if (finish_c && !killed_d) begin
            resp_valid_d = 1'b1;
            resp_exc_d   = fin_exc_c;
            resp_cause_d = fin_cause_c;
            resp_rdata_d = fin_rdata_c;
            resp_tag_d   = tag_d;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LSU_IDLE;
            ctrl_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            tag_q        <= '0;
            killed_q     <= 1'b0;
            c_cmd_q      <= CACHE_CMD_NONE;
            resp_valid_q <= 1'b0;
            resp_exc_q   <= 1'b0;
            resp_cause_q <= '0;
            resp_rdata_q <= '0;
            resp_tag_q   <= '0;
`ifdef COREVX_LSU_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            tag_q        <= tag_d;
            killed_q     <= killed_d;
            c_cmd_q      <= c_cmd_d;
            resp_valid_q <= resp_valid_d;
            resp_exc_q   <= resp_exc_d;
            resp_cause_q <= resp_cause_d;
            resp_rdata_q <= resp_rdata_d;
            resp_tag_q   <= resp_tag_d;
`ifdef COREVX_LSU_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_exc     = resp_exc_q;
    assign resp_cause   = resp_cause_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_tag     = resp_tag_q;
    assign c_cmd        = c_cmd_q;
    assign c_address    = addr_q;
    assign c_load_type  = ctrl_q.funct3;
    assign c_store_type = ctrl_q.funct3[1:0];
    assign c_store_data = wdata_q;

endmodule
